// File: rtl/msi_pkg.sv
// Shared encodings for the MSI L1 controller: line states, directory
// request codes, FSM states and a few helpers.
package msi_pkg;

    localparam int NUM_LINES = 4;

    // Line state as stored in the L1 array
    typedef enum logic [2:0] {
        LS_EMPTY = 3'b000,
        LS_I     = 3'b001,
        LS_S     = 3'b010,
        LS_M     = 3'b011
    } line_state_t;

    // HitOrMiss codes seen by the directory
    localparam logic [1:0] HOM_READ_MISS  = 2'b00;
    localparam logic [1:0] HOM_WRITE_MISS = 2'b01;
    localparam logic [1:0] HOM_HIT        = 2'b10;
    localparam logic [1:0] HOM_IDLE       = 2'b11;

    // Signal codes seen by the directory
    localparam logic [1:0] SIG_NONE  = 2'b00;
    localparam logic [1:0] SIG_READ  = 2'b01;
    localparam logic [1:0] SIG_WRITE = 2'b10;
    localparam logic [1:0] SIG_WB    = 2'b11;

    // Invalidate command codes; only INV_LINE has an effect
    localparam logic [1:0] INV_NONE = 2'b00;
    localparam logic [1:0] INV_LINE = 2'b01;

    // Requester codes on Processor
    localparam logic [1:0] PROC_NONE = 2'b00;
    localparam logic [1:0] PROC_P00  = 2'b01;
    localparam logic [1:0] PROC_P01  = 2'b10;

    // Encoded block addresses and data
    localparam logic [3:0] ADDR_EMPTY = 4'b0000;
    localparam logic [3:0] ADDR_100   = 4'b0001;
    localparam logic [3:0] ADDR_138   = 4'b1000;
    localparam logic [3:0] DATA_ZERO  = 4'b0000;

    // Controller FSM states
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_WB,
        ST_REQ,
        ST_WAIT_FILL,
        ST_RESPOND
    } fsm_state_t;

    // A line holds usable data only in S or M
    function automatic logic line_is_valid(input line_state_t s);
        return (s == LS_S) || (s == LS_M);
    endfunction

    // Miss/upgrade request encodings depend only on the access type
    function automatic logic [1:0] req_hom(input logic is_write);
        return is_write ? HOM_WRITE_MISS : HOM_READ_MISS;
    endfunction

    function automatic logic [1:0] req_sig(input logic is_write);
        return is_write ? SIG_WRITE : SIG_READ;
    endfunction

endpackage

// File: rtl/msi_l1_array.sv
// Four-entry direct-mapped tag/state/data store. The read port shows the
// state as it will look after any same-cycle invalidate, so a lookup racing
// an invalidate of its own line sees the line as I. On a simultaneous write
// and invalidate of the same line the write lands first and the invalidate
// is then applied on top of it.
module msi_l1_array
    import msi_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 4
) (
    input  logic              i_clk,
    input  logic              i_srst,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [ADDR_W-3:0] o_rd_tag,
    output line_state_t       o_rd_state,
    output logic [DATA_W-1:0] o_rd_data,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  line_state_t       i_wr_state,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_inv_en,
    input  logic [ADDR_W-1:0] i_inv_addr
);
    localparam int TAG_W = ADDR_W - 2;

    logic [TAG_W-1:0]  r_tag   [NUM_LINES];
    line_state_t       r_state [NUM_LINES];
    logic [DATA_W-1:0] r_data  [NUM_LINES];

    logic [TAG_W-1:0]  w_tag_next   [NUM_LINES];
    line_state_t       w_state_next [NUM_LINES];
    logic [DATA_W-1:0] w_data_next  [NUM_LINES];
    line_state_t       w_state_view [NUM_LINES];
    logic [NUM_LINES-1:0] w_wr_sel;
    logic [NUM_LINES-1:0] w_inv_now;
    logic [NUM_LINES-1:0] w_inv_next;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_LINES; gi++) begin : g_line
            assign w_wr_sel[gi]     = i_wr_en && (i_wr_addr[1:0] == 2'(gi));
            assign w_tag_next[gi]   = w_wr_sel[gi] ? i_wr_addr[ADDR_W-1:2] : r_tag[gi];
            assign w_state_next[gi] = w_wr_sel[gi] ? i_wr_state : r_state[gi];
            assign w_data_next[gi]  = w_wr_sel[gi] ? i_wr_data : r_data[gi];
            // Invalidate against the current contents (for the read view)
            assign w_inv_now[gi]    = i_inv_en && (i_inv_addr[1:0] == 2'(gi))
                                    && (i_inv_addr[ADDR_W-1:2] == r_tag[gi])
                                    && line_is_valid(r_state[gi]);
            // Invalidate against the post-write contents (for the update)
            assign w_inv_next[gi]   = i_inv_en && (i_inv_addr[1:0] == 2'(gi))
                                    && (i_inv_addr[ADDR_W-1:2] == w_tag_next[gi])
                                    && line_is_valid(w_state_next[gi]);
            assign w_state_view[gi] = w_inv_now[gi] ? LS_I : r_state[gi];
        end
    endgenerate

    assign o_rd_tag   = r_tag[i_rd_addr[1:0]];
    assign o_rd_state = w_state_view[i_rd_addr[1:0]];
    assign o_rd_data  = r_data[i_rd_addr[1:0]];

    // Commit writes and invalidates; reset empties every line
    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            for (int i = 0; i < NUM_LINES; i++) begin
                r_tag[i]   <= '0;
                r_state[i] <= LS_EMPTY;
                r_data[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_LINES; i++) begin
                r_tag[i]   <= w_tag_next[i];
                r_data[i]  <= w_data_next[i];
                r_state[i] <= w_inv_next[i] ? LS_I : w_state_next[i];
            end
        end
    end

endmodule

// File: rtl/msi_l1_controller.sv
// Private L1 controller: services CPU loads/stores from the MSI array,
// issues writeback and miss/upgrade requests to the directory, installs
// fills and applies directory invalidations.
module msi_l1_controller
    import msi_pkg::*;
#(
    parameter logic [1:0] PROC_ID = 2'b01,
    parameter int         ADDR_W  = 4,
    parameter int         DATA_W  = 4
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              CpuValid,
    input  logic              CpuWrite,
    input  logic [ADDR_W-1:0] CpuAddress,
    input  logic [DATA_W-1:0] CpuWriteData,
    output logic              CpuReady,
    output logic              CpuDone,
    output logic [DATA_W-1:0] CpuReadData,
    output logic              DirValid,
    input  logic              DirReady,
    output logic [1:0]        Processor,
    output logic [1:0]        HitOrMiss,
    output logic [1:0]        Signal,
    output logic [ADDR_W-1:0] DirAddress,
    output logic [DATA_W-1:0] DirData,
    input  logic              FillValid,
    input  logic [ADDR_W-1:0] FillAddress,
    input  logic [DATA_W-1:0] FillData,
    input  logic [1:0]        Invalidate,
    input  logic [ADDR_W-1:0] InvAddress
);
    fsm_state_t        r_state;
    logic [ADDR_W-1:0] r_addr;
    logic              r_write;
    logic [DATA_W-1:0] r_wdata;
    logic              r_cpu_ready;
    logic              r_cpu_done;
    logic [DATA_W-1:0] r_cpu_rdata;
    logic              r_dir_valid;
    logic [1:0]        r_processor;
    logic [1:0]        r_hom;
    logic [1:0]        r_signal;
    logic [ADDR_W-1:0] r_dir_addr;
    logic [DATA_W-1:0] r_dir_data;

    logic [ADDR_W-3:0] w_rd_tag;
    line_state_t       w_rd_state;
    logic [DATA_W-1:0] w_rd_data;
    logic              w_hit;
    logic              w_victim_dirty;
    logic              w_fill_match;
    logic              w_inv_en;
    logic              w_wr_en;
    logic [ADDR_W-1:0] w_wr_addr;
    line_state_t       w_wr_state;
    logic [DATA_W-1:0] w_wr_data;

    msi_l1_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_array (
        .i_clk      (Clock),
        .i_srst     (Reset),
        .i_rd_addr  (r_addr),
        .o_rd_tag   (w_rd_tag),
        .o_rd_state (w_rd_state),
        .o_rd_data  (w_rd_data),
        .i_wr_en    (w_wr_en),
        .i_wr_addr  (w_wr_addr),
        .i_wr_state (w_wr_state),
        .i_wr_data  (w_wr_data),
        .i_inv_en   (w_inv_en),
        .i_inv_addr (InvAddress)
    );

    assign w_inv_en       = (Invalidate == INV_LINE);
    assign w_hit          = (w_rd_tag == r_addr[ADDR_W-1:2]) && line_is_valid(w_rd_state);
    // M with no hit can only be another block sharing the index
    assign w_victim_dirty = !w_hit && (w_rd_state == LS_M);
    assign w_fill_match   = FillValid && (FillAddress == r_addr);

    // Array write port: store hit in M, victim drop after writeback, fill install
    always_comb begin
        w_wr_en    = 1'b0;
        w_wr_addr  = r_addr;
        w_wr_state = LS_I;
        w_wr_data  = r_wdata;
        case (r_state)
            ST_LOOKUP: begin
                if (r_write && w_hit && (w_rd_state == LS_M)) begin
                    w_wr_en    = 1'b1;
                    w_wr_state = LS_M;
                end
            end
            ST_WB: begin
                if (DirReady) begin
                    w_wr_en    = 1'b1;
                    w_wr_addr  = r_dir_addr;
                    w_wr_state = LS_I;
                    w_wr_data  = r_dir_data;
                end
            end
            ST_WAIT_FILL: begin
                if (w_fill_match) begin
                    w_wr_en    = 1'b1;
                    w_wr_state = r_write ? LS_M : LS_S;
                    w_wr_data  = r_write ? r_wdata : FillData;
                end
            end
            default: ;
        endcase
    end

    // Controller FSM with registered CPU and directory outputs
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state     <= ST_IDLE;
            r_addr      <= '0;
            r_write     <= 1'b0;
            r_wdata     <= '0;
            r_cpu_ready <= 1'b1;
            r_cpu_done  <= 1'b0;
            r_cpu_rdata <= '0;
            r_dir_valid <= 1'b0;
            r_processor <= PROC_NONE;
            r_hom       <= HOM_IDLE;
            r_signal    <= SIG_NONE;
            r_dir_addr  <= '0;
            r_dir_data  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (CpuValid && r_cpu_ready) begin
                        r_addr      <= CpuAddress;
                        r_write     <= CpuWrite;
                        r_wdata     <= CpuWriteData;
                        r_cpu_ready <= 1'b0;
                        r_state     <= ST_LOOKUP;
                    end
                end
                ST_LOOKUP: begin
                    if (w_hit && !(r_write && (w_rd_state == LS_S))) begin
                        // Read hit, or store hit in M: complete locally
                        r_cpu_done  <= 1'b1;
                        r_cpu_rdata <= r_write ? r_wdata : w_rd_data;
                        r_hom       <= HOM_HIT;
                        r_state     <= ST_RESPOND;
                    end else if (w_victim_dirty) begin
                        // Dirty block in the way: write it back first
                        r_dir_valid <= 1'b1;
                        r_processor <= PROC_ID;
                        r_hom       <= HOM_IDLE;
                        r_signal    <= SIG_WB;
                        r_dir_addr  <= {w_rd_tag, r_addr[1:0]};
                        r_dir_data  <= w_rd_data;
                        r_state     <= ST_WB;
                    end else begin
                        // Miss or upgrade from S
                        r_dir_valid <= 1'b1;
                        r_processor <= PROC_ID;
                        r_hom       <= req_hom(r_write);
                        r_signal    <= req_sig(r_write);
                        r_dir_addr  <= r_addr;
                        r_state     <= ST_REQ;
                    end
                end
                ST_WB: begin
                    if (DirReady) begin
                        r_hom      <= req_hom(r_write);
                        r_signal   <= req_sig(r_write);
                        r_dir_addr <= r_addr;
                        r_dir_data <= '0;
                        r_state    <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (DirReady) begin
                        r_dir_valid <= 1'b0;
                        r_processor <= PROC_NONE;
                        r_hom       <= HOM_IDLE;
                        r_signal    <= SIG_NONE;
                        r_dir_addr  <= '0;
                        r_state     <= ST_WAIT_FILL;
                    end
                end
                ST_WAIT_FILL: begin
                    if (w_fill_match) begin
                        r_cpu_done  <= 1'b1;
                        r_cpu_rdata <= r_write ? r_wdata : FillData;
                        r_state     <= ST_RESPOND;
                    end
                end
                ST_RESPOND: begin
                    r_cpu_done  <= 1'b0;
                    r_hom       <= HOM_IDLE;
                    r_cpu_ready <= 1'b1;
                    r_state     <= ST_IDLE;
                end
                default: begin
                    r_cpu_ready <= 1'b1;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign CpuReady    = r_cpu_ready;
    assign CpuDone     = r_cpu_done;
    assign CpuReadData = r_cpu_rdata;
    assign DirValid    = r_dir_valid;
    assign Processor   = r_processor;
    assign HitOrMiss   = r_hom;
    assign Signal      = r_signal;
    assign DirAddress  = r_dir_addr;
    assign DirData     = r_dir_data;

endmodule

// File: tb/tb_msi_l1_controller.sv
// Directed bench for msi_l1_controller: a per-cycle table of stimulus and
// expected outputs, followed by a hand-written reset-during-request sequence.
module tb_msi_l1_controller;

    logic       Clock = 1'b0;
    logic       Reset;
    logic       CpuValid, CpuWrite;
    logic [3:0] CpuAddress, CpuWriteData;
    logic       CpuReady, CpuDone;
    logic [3:0] CpuReadData;
    logic       DirValid, DirReady;
    logic [1:0] Processor, HitOrMiss, Signal;
    logic [3:0] DirAddress, DirData;
    logic       FillValid;
    logic [3:0] FillAddress, FillData;
    logic [1:0] Invalidate;
    logic [3:0] InvAddress;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 Clock = ~Clock;

    msi_l1_controller #(.PROC_ID(2'b01), .ADDR_W(4), .DATA_W(4)) dut (
        .Clock(Clock), .Reset(Reset),
        .CpuValid(CpuValid), .CpuWrite(CpuWrite), .CpuAddress(CpuAddress),
        .CpuWriteData(CpuWriteData), .CpuReady(CpuReady), .CpuDone(CpuDone),
        .CpuReadData(CpuReadData), .DirValid(DirValid), .DirReady(DirReady),
        .Processor(Processor), .HitOrMiss(HitOrMiss), .Signal(Signal),
        .DirAddress(DirAddress), .DirData(DirData), .FillValid(FillValid),
        .FillAddress(FillAddress), .FillData(FillData),
        .Invalidate(Invalidate), .InvAddress(InvAddress)
    );

    typedef struct {
        logic       rst, cv, cw;
        logic [3:0] ca, cd;
        logic       dr, fv;
        logic [3:0] fa, fd;
        logic [1:0] inv;
        logic [3:0] ia;
    } stim_t;

    typedef struct {
        logic       chk;
        logic       ready, done, dv;
        logic [1:0] proc, hom, sig;
        logic [3:0] da, dd, rd;
        logic       c_hom, c_sig, c_da, c_dd, c_rd;
    } exp_t;

    typedef struct {
        stim_t s;
        exp_t  e;
    } vec_t;

    vec_t tbl[$];

    function automatic stim_t s_none();
        stim_t s;
        s.rst = 0; s.cv = 0; s.cw = 0; s.ca = 0; s.cd = 0; s.dr = 0;
        s.fv = 0; s.fa = 0; s.fd = 0; s.inv = 2'b00; s.ia = 0;
        return s;
    endfunction
    function automatic stim_t s_rst();
        stim_t s = s_none(); s.rst = 1; return s;
    endfunction
    function automatic stim_t s_rd(input logic [3:0] a);
        stim_t s = s_none(); s.cv = 1; s.ca = a; return s;
    endfunction
    function automatic stim_t s_wr(input logic [3:0] a, input logic [3:0] d);
        stim_t s = s_none(); s.cv = 1; s.cw = 1; s.ca = a; s.cd = d; return s;
    endfunction
    function automatic stim_t s_dr();
        stim_t s = s_none(); s.dr = 1; return s;
    endfunction
    function automatic stim_t s_fill(input logic [3:0] a, input logic [3:0] d);
        stim_t s = s_none(); s.fv = 1; s.fa = a; s.fd = d; return s;
    endfunction
    function automatic stim_t s_inv_on(input stim_t b, input logic [1:0] code, input logic [3:0] a);
        stim_t s = b; s.inv = code; s.ia = a; return s;
    endfunction

    function automatic exp_t e_base();
        exp_t e;
        e.chk = 1; e.ready = 0; e.done = 0; e.dv = 0; e.proc = 2'b00;
        e.hom = 2'b11; e.sig = 2'b00; e.da = 0; e.dd = 0; e.rd = 0;
        e.c_hom = 0; e.c_sig = 0; e.c_da = 0; e.c_dd = 0; e.c_rd = 0;
        return e;
    endfunction
    function automatic exp_t e_none();
        exp_t e = e_base(); e.chk = 0; return e;
    endfunction
    function automatic exp_t e_rst();
        exp_t e = e_base();
        e.ready = 1; e.c_hom = 1; e.c_sig = 1; e.c_da = 1; e.c_dd = 1; e.c_rd = 1;
        return e;
    endfunction
    function automatic exp_t e_idle();
        exp_t e = e_base(); e.ready = 1; e.c_hom = 1; return e;
    endfunction
    function automatic exp_t e_busy();
        exp_t e = e_base(); return e;
    endfunction
    function automatic exp_t e_req(input logic [1:0] h, input logic [1:0] sg, input logic [3:0] a);
        exp_t e = e_base();
        e.dv = 1; e.proc = 2'b01; e.hom = h; e.sig = sg; e.da = a;
        e.c_hom = 1; e.c_sig = 1; e.c_da = 1;
        return e;
    endfunction
    function automatic exp_t e_wb(input logic [3:0] a, input logic [3:0] d);
        exp_t e = e_base();
        e.dv = 1; e.proc = 2'b01; e.sig = 2'b11; e.da = a; e.dd = d;
        e.c_sig = 1; e.c_da = 1; e.c_dd = 1;
        return e;
    endfunction
    function automatic exp_t e_done(input logic crd, input logic [3:0] rd,
                                    input logic chom, input logic [1:0] h);
        exp_t e = e_base();
        e.done = 1; e.c_rd = crd; e.rd = rd; e.c_hom = chom; e.hom = h;
        return e;
    endfunction

    task automatic add(input stim_t s, input exp_t e);
        vec_t v;
        v.s = s; v.e = e;
        tbl.push_back(v);
    endtask

    task automatic cmp(input string nm, input logic [3:0] act, input logic [3:0] want);
        n_cmp++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", nm, act, want);
        end
    endtask

    task automatic apply(input stim_t s);
        Reset = s.rst; CpuValid = s.cv; CpuWrite = s.cw; CpuAddress = s.ca;
        CpuWriteData = s.cd; DirReady = s.dr; FillValid = s.fv; FillAddress = s.fa;
        FillData = s.fd; Invalidate = s.inv; InvAddress = s.ia;
    endtask

    task automatic check_row(input int i, input exp_t e);
        if (e.chk) begin
            cmp($sformatf("r%0d.ready", i), 4'(CpuReady), 4'(e.ready));
            cmp($sformatf("r%0d.done", i), 4'(CpuDone), 4'(e.done));
            cmp($sformatf("r%0d.dirvalid", i), 4'(DirValid), 4'(e.dv));
            cmp($sformatf("r%0d.processor", i), 4'(Processor), 4'(e.proc));
            if (e.c_hom) cmp($sformatf("r%0d.hitormiss", i), 4'(HitOrMiss), 4'(e.hom));
            if (e.c_sig) cmp($sformatf("r%0d.signal", i), 4'(Signal), 4'(e.sig));
            if (e.c_da)  cmp($sformatf("r%0d.diraddr", i), DirAddress, e.da);
            if (e.c_dd)  cmp($sformatf("r%0d.dirdata", i), DirData, e.dd);
            if (e.c_rd)  cmp($sformatf("r%0d.readdata", i), CpuReadData, e.rd);
        end
    endtask

    initial begin
        // Row k: outputs expected at this negedge, stimulus for the next posedge
        add(s_rst(),                 e_none());                        // 0
        add(s_rd(4'b0001),           e_rst());                         // 1 reset state
        add(s_none(),                e_busy());                        // 2 LOOKUP
        add(s_none(),                e_req(2'b00, 2'b01, 4'b0001));    // 3 read miss
        add(s_dr(),                  e_req(2'b00, 2'b01, 4'b0001));    // 4
        add(s_fill(4'b0010, 4'b1111), e_busy());                       // 5 foreign fill
        add(s_fill(4'b0001, 4'b0010), e_busy());                       // 6
        add(s_none(),                e_done(1, 4'b0010, 0, 2'b11));    // 7
        add(s_rd(4'b0001),           e_idle());                        // 8
        add(s_none(),                e_busy());                        // 9
        add(s_none(),                e_done(1, 4'b0010, 1, 2'b10));    // 10 read hit
        add(s_wr(4'b0001, 4'b0110),  e_idle());                        // 11
        add(s_none(),                e_busy());                        // 12
        add(s_dr(),                  e_req(2'b01, 2'b10, 4'b0001));    // 13 upgrade
        add(s_fill(4'b0001, 4'b1010), e_busy());                       // 14
        add(s_none(),                e_done(0, 4'b0000, 0, 2'b11));    // 15
        add(s_rd(4'b0101),           e_idle());                        // 16
        add(s_none(),                e_busy());                        // 17
        add(s_dr(),                  e_wb(4'b0001, 4'b0110));          // 18 writeback
        for (int k = 0; k < 5; k++)
            add(s_none(),            e_req(2'b00, 2'b01, 4'b0101));    // 19-23 stall
        add(s_dr(),                  e_req(2'b00, 2'b01, 4'b0101));    // 24
        add(s_inv_on(s_fill(4'b0101, 4'b0100), 2'b01, 4'b0101), e_busy()); // 25
        add(s_none(),                e_done(1, 4'b0100, 0, 2'b11));    // 26
        add(s_rd(4'b0101),           e_idle());                        // 27
        add(s_none(),                e_busy());                        // 28
        add(s_dr(),                  e_req(2'b00, 2'b01, 4'b0101));    // 29 miss, no WB
        add(s_rst(),                 e_busy());                        // 30 reset in WAIT_FILL
        add(s_rd(4'b0010),           e_rst());                         // 31
        add(s_none(),                e_busy());                        // 32
        add(s_dr(),                  e_req(2'b00, 2'b01, 4'b0010));    // 33
        add(s_inv_on(s_fill(4'b0010, 4'b0011), 2'b01, 4'b0110), e_busy()); // 34 tag differs
        add(s_none(),                e_done(1, 4'b0011, 0, 2'b11));    // 35
        add(s_inv_on(s_rd(4'b0010), 2'b10, 4'b0010), e_idle());        // 36 ignored code
        add(s_none(),                e_busy());                        // 37
        add(s_none(),                e_done(1, 4'b0011, 1, 2'b10));    // 38 still S
        add(s_rd(4'b0010),           e_idle());                        // 39
        add(s_inv_on(s_none(), 2'b01, 4'b0010), e_busy());             // 40 inv in LOOKUP
        add(s_dr(),                  e_req(2'b00, 2'b01, 4'b0010));    // 41
        add(s_fill(4'b0010, 4'b0111), e_busy());                       // 42
        add(s_none(),                e_done(1, 4'b0111, 0, 2'b11));    // 43
        add(s_wr(4'b1100, 4'b1001),  e_idle());                        // 44
        add(s_none(),                e_busy());                        // 45
        add(s_dr(),                  e_req(2'b01, 2'b10, 4'b1100));    // 46 write miss
        add(s_fill(4'b1100, 4'b0000), e_busy());                       // 47
        add(s_none(),                e_done(0, 4'b0000, 0, 2'b11));    // 48
        add(s_rd(4'b1100),           e_idle());                        // 49
        add(s_none(),                e_busy());                        // 50
        add(s_none(),                e_done(1, 4'b1001, 1, 2'b10));    // 51 M holds store
        add(s_wr(4'b1100, 4'b0101),  e_idle());                        // 52
        add(s_none(),                e_busy());                        // 53
        add(s_none(),                e_done(0, 4'b0000, 0, 2'b11));    // 54 store hit in M
        add(s_rd(4'b1100),           e_idle());                        // 55
        add(s_none(),                e_busy());                        // 56
        add(s_none(),                e_done(1, 4'b0101, 1, 2'b10));    // 57
        add(s_inv_on(s_none(), 2'b01, 4'b0011), e_idle());             // 58 empty line

        apply(s_none());
        foreach (tbl[i]) begin
            @(negedge Clock);
            check_row(i, tbl[i].e);
            $display("row %0d: rdy=%0b done=%0b rd=%h dv=%0b p=%b hm=%b sig=%b da=%h dd=%h",
                     i, CpuReady, CpuDone, CpuReadData, DirValid, Processor,
                     HitOrMiss, Signal, DirAddress, DirData);
            apply(tbl[i].s);
        end

        // Reset while a request is outstanding: DirValid drops, no completion
        @(negedge Clock);
        apply(s_rd(4'b0011));
        @(negedge Clock);
        apply(s_none());
        begin
            int k = 0;
            while (!DirValid && k < 8) begin
                @(negedge Clock);
                k++;
            end
        end
        cmp("seq.dirvalid_seen", 4'(DirValid), 4'd1);
        cmp("seq.hitormiss", 4'(HitOrMiss), 4'd0);
        cmp("seq.signal", 4'(Signal), 4'd1);
        cmp("seq.diraddr", DirAddress, 4'b0011);
        $display("seq: request dv=%0b hm=%b sig=%b da=%h", DirValid, HitOrMiss, Signal, DirAddress);
        Reset = 1'b1;
        @(negedge Clock);
        Reset = 1'b0;
        cmp("seq.dirvalid_after_reset", 4'(DirValid), 4'd0);
        cmp("seq.processor_after_reset", 4'(Processor), 4'd0);
        cmp("seq.hitormiss_after_reset", 4'(HitOrMiss), 4'd3);
        $display("seq: after reset dv=%0b p=%b hm=%b", DirValid, Processor, HitOrMiss);
        for (int k = 0; k < 4; k++) begin
            @(negedge Clock);
            cmp($sformatf("seq.no_done%0d", k), 4'(CpuDone), 4'd0);
            cmp($sformatf("seq.ready%0d", k), 4'(CpuReady), 4'd1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/msi_l1_controller.md
Name: msi_l1_controller

Overview:
Private L1 cache controller for one processor (P0,0 or P0,1) in the two-processor MSI directory system.
- Sits directly upstream of the L2 directory list.
- Services CPU loads/stores from a 4-line direct-mapped MSI array.
- On a miss or upgrade, produces the Processor, HitOrMiss and Signal request codes the directory consumes, then installs the fill returned from the directory/memory path.
- Applies directory invalidations.

Parameters:
PROC_ID, 2'b01, requester code driven on Processor (2'b01 = P0,0; 2'b10 = P0,1).
ADDR_W, 4, encoded block address width (0001 = 100 … 1000 = 138; 0000 = empty).
DATA_W, 4, encoded data width.

Ports:
Clock  in  1  system clock; all state updates on posedge.
Reset  in  1  synchronous, active-high reset.
CpuValid  in  1  CPU request strobe.
CpuWrite  in  1  1 = store, 0 = load.
CpuAddress  in  ADDR_W  request address.
CpuWriteData  in  DATA_W  store data.
CpuReady  out  1  high only in IDLE; request accepted when CpuValid && CpuReady.
CpuDone  out  1  one-cycle completion pulse.
CpuReadData  out  DATA_W  load result, valid while CpuDone.
DirValid  out  1  request to directory.
DirReady  in  1  directory accepts when DirValid && DirReady.
Processor  out  2  PROC_ID while DirValid, else 2'b00.
HitOrMiss  out  2  00 read miss, 01 write miss, 10 hit, 11 idle.
Signal  out  2  00 none, 01 read request (Sharers = {P}), 10 write/upgrade request, 11 writeback.
DirAddress  out  ADDR_W  request/writeback address.
DirData  out  DATA_W  writeback data (Signal = 11 only).
FillValid  in  1  fill response strobe.
FillAddress  in  ADDR_W  fill address.
FillData  in  DATA_W  fill data.
Invalidate  in  2  01 = invalidate InvAddress; all other codes ignored.
InvAddress  in  ADDR_W  invalidation target.

Behaviour:
- Array: 4 lines, index = addr[1:0], tag = addr[3:2].
- Line state codes: 000 empty, 001 I, 010 S, 011 M. A hit requires tag match and state S or M.
- Reset: all lines empty, data 0. CpuDone = 0, CpuReadData = 0, DirValid = 0, Processor = 00, HitOrMiss = 11, Signal = 00, DirAddress = 0, DirData = 0. FSM enters IDLE.
- FSM states: IDLE, LOOKUP, WB, REQ, WAIT_FILL, RESPOND.
- IDLE -> LOOKUP on accept; address, write flag and data are latched.
- LOOKUP, hit cases:
  - Read hit (S or M): go to RESPOND, HitOrMiss = 10.
  - Write hit in M: update data, go to RESPOND.
  - Write hit in S: upgrade, go to REQ with HitOrMiss 01, Signal 10.
- LOOKUP, miss cases (tag mismatch or I/empty):
  - If the victim is in M: go to WB.
  - Otherwise go to REQ (read miss: 00/01; write miss: 01/10).
- WB: DirValid = 1, Signal = 11, DirAddress = victim address, DirData = victim data. On DirReady, victim becomes I and FSM goes to REQ.
- REQ: DirValid held until DirReady. Processor, HitOrMiss, Signal and DirAddress are stable while DirValid is high. Then go to WAIT_FILL.
- WAIT_FILL: waits for FillValid with FillAddress equal to the latched address; non-matching fills are ignored. On a match, install the line (read -> S with FillData; write -> M with CpuWriteData), then go to RESPOND.
- RESPOND: CpuDone = 1 for one cycle; CpuReadData = line data (loads). HitOrMiss returns to 11. Go to IDLE.
- Latency: read hit completes 2 cycles after accept (CpuDone asserts in the 2nd cycle). Miss latency = 2 + DirReady wait + fill wait.
- Invalidate: applied in the same cycle in any state. A matching line in S/M goes to I; empty lines and non-matching tags are unaffected.
- Invalidate vs. fill, same address and same cycle: the fill installs, then the invalidate wins, so the final state is I. The CPU still receives the fill data for a read.
- Invalidate during LOOKUP of the same line: hit/miss is decided on the post-invalidate state, so the request is treated as a miss.
- Reset mid-transaction aborts it: DirValid drops the next cycle and no CpuDone is issued.

Decomposition:
- Shared package msi_pkg holds:
  - line-state codes (EMPTY/I/S/M);
  - HitOrMiss codes;
  - Signal codes;
  - Invalidate codes;
  - encoded address/data constants.
- One natural sub-module: msi_l1_array, the 4-entry tag/state/data storage with read port, write port and invalidate port. The FSM lives in msi_l1_controller.

Test Plan:
- After Reset, read 0001 -> REQ with Processor 01, HitOrMiss 00, Signal 01, DirAddress 0001. Fill 0001/0010 -> line S, CpuDone with CpuReadData 0010.
- Read 0001 again -> CpuDone 2 cycles after accept, no DirValid, HitOrMiss 10.
- Write 0001 data 0110 while line in S -> upgrade request HitOrMiss 01, Signal 10. Fill 0001 -> line M with data 0110.
- Read 0101 (same index as 0001, line in M) -> writeback first (Signal 11, DirAddress 0001, DirData 0110), then read miss for 0101.
- Invalidate 01 with InvAddress 0101 asserted in the same cycle as FillValid 0101/0100 -> CpuReadData 0100, final line state I; next read of 0101 misses.
- DirReady held low 5 cycles -> DirValid and all request fields stable throughout. Reset in WAIT_FILL -> outputs return to reset values, no CpuDone.
